// File: rtl/radar_sync_sequencer.sv
// Programmable PRI sequencer for the time-domain radar synchronizer: generates MCU/TX/RX-gate
// pulses per PRI and sweeps the RX gate offset one cycle per A-scan point.
module radar_sync_sequencer #(
  parameter int unsigned CW = 16,
  parameter int unsigned PW = 8,
  parameter int unsigned AW = 16
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          start,
  input  logic          stop,
  output logic          mcu_out,
  output logic          tx_out,
  output logic          rx_out,
  output logic          prt_tick,
  output logic [PW-1:0] point_idx,
  output logic          ascan_done,
  output logic          busy,
  output logic          cfg_err
);

  typedef enum logic [1:0] {StIdle, StRun, StStopPend} state_e;

  localparam logic [CW-1:0] DefPrtDiv  = CW'(5000);
  localparam logic [CW-1:0] DefMcuHigh = CW'(200);
  localparam logic [CW-1:0] DefTxHigh  = CW'(30);
  localparam logic [CW-1:0] DefRxStart = CW'(80);
  localparam logic [CW-1:0] DefRxEnd   = CW'(180);
  localparam logic [AW-1:0] DefAvg     = AW'(1);
  localparam logic [CW:0]   MaxSpan    = {{CW{1'b0}}, 1'b1} << PW;

  logic [CW-1:0] prt_div_q, mcu_high_q, tx_high_q, rx_start_q, rx_end_q;
  logic [AW-1:0] avg_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] off_q, off_d;
  logic [AW-1:0] avg_cnt_q, avg_cnt_d;

  logic          cfg_ok, pri_end, avg_wrap, sweep_end;
  logic          run_d, done_d;
  logic [CW-1:0] span;

  always_comb begin
    span      = rx_end_q - rx_start_q;
    cfg_ok    = (prt_div_q >= CW'(2)) && (mcu_high_q < prt_div_q) && (tx_high_q < prt_div_q) &&
                (rx_start_q < rx_end_q) && (rx_end_q <= prt_div_q) && (avg_q != '0) &&
                ({1'b0, span} <= MaxSpan);
    pri_end   = (cnt_q == prt_div_q);
    avg_wrap  = ((avg_cnt_q + AW'(1)) == avg_q);
    sweep_end = avg_wrap && ((off_q + CW'(1)) == rx_end_q);

    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    avg_cnt_d = avg_cnt_q;

    case (state_q)
      StIdle: begin
        if (start && cfg_ok) begin
          state_d   = StRun;
          cnt_d     = CW'(1);
          off_d     = rx_start_q;
          avg_cnt_d = '0;
        end
      end
      StRun, StStopPend: begin
        if (state_q == StRun && stop) state_d = StStopPend;
        if (pri_end) begin
          cnt_d = CW'(1);
          if (avg_wrap) begin
            avg_cnt_d = '0;
            off_d     = sweep_end ? rx_start_q : off_q + CW'(1);
          end else begin
            avg_cnt_d = avg_cnt_q + AW'(1);
          end
          if (state_q == StStopPend) state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from next-state values so they line up with the cycle's count.
    run_d  = (state_d != StIdle);
    done_d = run_d && (cnt_d == prt_div_q) && ((avg_cnt_d + AW'(1)) == avg_q) &&
             ((off_d + CW'(1)) == rx_end_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      prt_div_q  <= DefPrtDiv;
      mcu_high_q <= DefMcuHigh;
      tx_high_q  <= DefTxHigh;
      rx_start_q <= DefRxStart;
      rx_end_q   <= DefRxEnd;
      avg_q      <= DefAvg;
      state_q    <= StIdle;
      cnt_q      <= '0;
      off_q      <= '0;
      avg_cnt_q  <= '0;
      mcu_out    <= 1'b0;
      tx_out     <= 1'b0;
      rx_out     <= 1'b0;
      prt_tick   <= 1'b0;
      point_idx  <= '0;
      ascan_done <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (cfg_wr && state_q == StIdle) begin
        case (cfg_addr)
          3'd0:    prt_div_q  <= cfg_wdata;
          3'd1:    mcu_high_q <= cfg_wdata;
          3'd2:    tx_high_q  <= cfg_wdata;
          3'd3:    rx_start_q <= cfg_wdata;
          3'd4:    rx_end_q   <= cfg_wdata;
          3'd5:    avg_q      <= cfg_wdata[AW-1:0];
          default: ;
        endcase
      end
      if (state_q == StIdle && start) cfg_err <= !cfg_ok;

      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      avg_cnt_q  <= avg_cnt_d;

      mcu_out    <= run_d && (cnt_d <= mcu_high_q);
      tx_out     <= run_d && (cnt_d <= tx_high_q);
      rx_out     <= run_d && (cnt_d > off_d) && (cnt_d <= rx_end_q);
      prt_tick   <= run_d && (cnt_d == CW'(1));
      point_idx  <= run_d ? PW'(off_d - rx_start_q) : '0;
      ascan_done <= done_d;
      busy       <= run_d;
    end
  end

endmodule
